// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its UART operand sequencer.
// Contents: default widths, the supported opcode list and the sequencer
// state type.
package alu_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_CALC    = 3'd3,
        S_WAIT_TX = 3'd4
    } state_e;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bus between the operand sequencer and its surroundings (uart_rx, uart_tx,
// alu). master: the sequencer. slave: the UART/alu side.
//   rx_data/rx_done   received byte + 1-cycle strobe
//   data_a/data_b     operands to alu
//   operation         opcode to alu
//   alu_result        combinational alu result
//   tx_data/tx_start  result byte + 1-cycle start strobe to uart_tx
//   tx_done           1-cycle strobe from uart_tx
//   op_error          1-cycle strobe: unsupported opcode
//   rx_overrun        1-cycle strobe: RX byte dropped
interface alu_uart_interface_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] rx_data;
    logic               rx_done;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_OP-1:0]   operation;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               op_error;
    logic               rx_overrun;

    modport master (
        input  rx_data, rx_done, alu_result, tx_done,
        output data_a, data_b, operation, tx_data, tx_start, op_error, rx_overrun
    );

    modport slave (
        output rx_data, rx_done, alu_result, tx_done,
        input  data_a, data_b, operation, tx_data, tx_start, op_error, rx_overrun
    );
endinterface

// File: rtl/alu_op_check.sv
// Combinational opcode validity check, shared with the alu so both blocks
// accept exactly the same opcode list.
//   i_operation  opcode under test
//   o_valid      1 when the opcode is supported
module alu_op_check
    import alu_pkg::*;
#(
    parameter int unsigned NB_OP = NB_OP_DEF
) (
    input  logic [NB_OP-1:0] i_operation,
    output logic             o_valid
);
    always_comb begin
        o_valid = i_operation inside {
            NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
            NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL)
        };
    end
endmodule

// File: rtl/alu_uart_interface.sv
// Operand sequencer / result return path between uart_rx, alu and uart_tx.
// Collects A, B and opcode bytes, holds them on the alu inputs, captures the
// alu result and starts a UART transmission of it.
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      alu_uart_interface_if.master (RX, alu, TX and status strobes)
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_OP   = NB_OP_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    alu_uart_interface_if.master  bus
);
    state_e             state_q,    state_d;
    logic [NB_DATA-1:0] data_a_q,   data_a_d;
    logic [NB_DATA-1:0] data_b_q,   data_b_d;
    logic [NB_OP-1:0]   op_q,       op_d;
    logic               op_pend_q,  op_pend_d;
    logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               op_err_q,   op_err_d;
    logic               overrun_q,  overrun_d;
    logic               op_valid;

    // Validity is judged on the registered opcode, i.e. the value the alu sees.
    alu_op_check #(.NB_OP(NB_OP)) u_op_check (
        .i_operation (op_q),
        .o_valid     (op_valid)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            op_pend_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            op_err_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            op_pend_q  <= op_pend_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            op_err_q   <= op_err_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        op_pend_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        op_err_d   = 1'b0;
        overrun_d  = 1'b0;
        unique case (state_q)
            S_WAIT_A: begin
                if (bus.rx_done) begin
                    data_a_d = bus.rx_data;
                    state_d  = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (bus.rx_done) begin
                    data_b_d = bus.rx_data;
                    state_d  = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                // Opcode is registered first, then checked one cycle later;
                // this places the TX start two cycles after the opcode edge.
                if (op_pend_q) begin
                    overrun_d = bus.rx_done;
                    if (op_valid) begin
                        state_d = S_CALC;
                    end else begin
                        op_err_d = 1'b1;
                        state_d  = S_WAIT_A;
                    end
                end else if (bus.rx_done) begin
                    op_d      = bus.rx_data[NB_OP-1:0];
                    op_pend_d = 1'b1;
                end
            end
            S_CALC: begin
                overrun_d  = bus.rx_done;
                tx_data_d  = bus.alu_result;
                tx_start_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = bus.rx_done;
                // A done strobe coincident with our own start belongs to
                // nothing we launched.
                if (bus.tx_done && !tx_start_q) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    assign bus.data_a     = data_a_q;
    assign bus.data_b     = data_b_q;
    assign bus.operation  = op_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.op_error   = op_err_q;
    assign bus.rx_overrun = overrun_q;
endmodule
